// File: rtl/multi_edge_detect.sv
// Multi-channel synchronised edge detector: stretched pulses, sticky flags and a saturating event counter.
// Optional glitch filter between synchroniser and edge compare is enabled by defining MULTI_EDGE_FILTER_EN.
module multi_edge_detect #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 8,
    parameter int FILTER_LEN  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     sticky_clr,
    input  logic                  cnt_clr,
    output logic [NUM_CH-1:0]     out,
    output logic [NUM_CH-1:0]     sticky,
    output logic [CNT_W-1:0]      event_cnt
);

`ifdef MULTI_EDGE_FILTER_EN
    localparam int ARM_LEN = SYNC_STAGES + 1 + FILTER_LEN;
`else
    localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_LEN + 1);
    localparam int STR_W = $clog2(PULSE_LEN + 1);
    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 2 || PULSE_LEN < 1 || FILTER_LEN < 1) begin : g_bad_param
        $error("multi_edge_detect: parameter out of range");
    end

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] rise_en;
    logic [NUM_CH-1:0] fall_en;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] out_nxt;
    logic [ARM_W-1:0]  arm_cnt;
    logic              armed;
    logic [STR_W-1:0]  stretch     [NUM_CH];
    logic [STR_W-1:0]  stretch_nxt [NUM_CH];
    logic [POP_W-1:0]  pop;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    logic [FLT_W-1:0] flt_cnt [NUM_CH];

    // filt only takes a new value once sync_out has disagreed for FILTER_LEN straight cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync_out[i] != filt[i]) begin
                    if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                        filt[i]    <= sync_out[i];
                        flt_cnt[i] <= '0;
                    end else begin
                        flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
                    end
                end else begin
                    flt_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync_out;
`endif

    assign armed = (arm_cnt == ARM_W'(ARM_LEN));

    always_comb begin
        rise_en = '0;
        fall_en = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rise_en[i] = mode[2*i];
            fall_en[i] = mode[2*i+1];
        end
    end

    assign q = armed ? ((filt & ~lvl & rise_en) | (~filt & lvl & fall_en)) : '0;

    always_comb begin
        out_nxt = '0;
        pop     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (q[i]) begin
                stretch_nxt[i] = STR_W'(PULSE_LEN);
            end else if (stretch[i] != '0) begin
                stretch_nxt[i] = stretch[i] - STR_W'(1);
            end else begin
                stretch_nxt[i] = '0;
            end
            out_nxt[i] = (stretch_nxt[i] != '0);
            pop        = pop + POP_W'(q[i]);
        end
    end

    // cnt_clr drops the old total but still counts this cycle's events
    always_comb begin
        sum     = (cnt_clr ? '0 : SUM_W'(event_cnt)) + SUM_W'(pop);
        cnt_nxt = (sum > SAT) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl       <= '0;
            arm_cnt   <= '0;
            out       <= '0;
            sticky    <= '0;
            event_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stretch[i] <= '0;
            end
        end else begin
            lvl <= filt;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stretch[i] <= stretch_nxt[i];
            end
            out       <= out_nxt;
            sticky    <= (sticky & ~sticky_clr) | q;
            event_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: default instance plus PULSE_LEN=4 and CNT_W=3 variants on shared stimulus.
// Expected latencies follow MULTI_EDGE_FILTER_EN when the bench is built with it.
module tb_multi_edge_detect;

`ifdef MULTI_EDGE_FILTER_EN
    localparam int FLT = 3;
`else
    localparam int FLT = 0;
`endif
    localparam int LAT = 3 + FLT;
    localparam int ARM = 3 + FLT;
    localparam int GAP = (FLT == 0) ? 1 : FLT;
    localparam int HI  = (FLT == 0) ? 2 : FLT;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in;
    logic [7:0] mode;
    logic [3:0] sticky_clr;
    logic       cnt_clr;
    logic [3:0] out_a, sticky_a, out_b, sticky_b, out_c, sticky_c;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    multi_edge_detect dut_a (
        .clk(clk), .reset(reset), .in(in), .mode(mode), .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr), .out(out_a), .sticky(sticky_a), .event_cnt(cnt_a)
    );

    multi_edge_detect #(.PULSE_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .in(in), .mode(mode), .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr), .out(out_b), .sticky(sticky_b), .event_cnt(cnt_b)
    );

    multi_edge_detect #(.CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .in(in), .mode(mode), .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr), .out(out_c), .sticky(sticky_c), .event_cnt(cnt_c)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] lvl, input logic [7:0] m);
        in = lvl; mode = m; sticky_clr = '0; cnt_clr = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] seen;
        do_reset(4'hF, 8'hFF);
        checks++; if ({out_a, sticky_a, cnt_a} !== 16'h0) $display("FAIL reset_state: got %h expected 0000", {out_a, sticky_a, cnt_a}); else passes++;
        checks++; if ({out_c, sticky_c, cnt_c} !== 11'h0) $display("FAIL reset_state_c: got %h expected 000", {out_c, sticky_c, cnt_c}); else passes++;
        seen = '0;
        for (int k = 0; k < ARM + 6; k++) begin
            step(1);
            seen = seen | out_a | out_b;
        end
        checks++; if (seen !== 4'h0) $display("FAIL static_high_out: got %b expected 0000", seen); else passes++;
        checks++; if (sticky_a !== 4'h0) $display("FAIL static_high_sticky: got %b expected 0000", sticky_a); else passes++;
        checks++; if (cnt_a !== 8'd0) $display("FAIL static_high_cnt: got %0d expected 0", cnt_a); else passes++;
    endtask

    task automatic test_single_rise;
        logic ea, eb;
        do_reset(4'h0, 8'h55);
        step(ARM + 1);
        in = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            ea = (k == LAT);
            eb = (k >= LAT && k <= LAT + 3);
            checks++; if (out_a !== {3'b000, ea}) $display("FAIL rise_out k=%0d: got %b expected %b", k, out_a, {3'b000, ea}); else passes++;
            checks++; if (out_b !== {3'b000, eb}) $display("FAIL rise_out_p4 k=%0d: got %b expected %b", k, out_b, {3'b000, eb}); else passes++;
        end
        checks++; if (sticky_a !== 4'b0001) $display("FAIL rise_sticky: got %b expected 0001", sticky_a); else passes++;
        checks++; if (cnt_a !== 8'd1) $display("FAIL rise_cnt: got %0d expected 1", cnt_a); else passes++;
    endtask

    task automatic test_retrigger;
        logic ea, eb;
        do_reset(4'h0, 8'hFF);
        step(ARM + 1);
        in = 4'b0010;
        for (int k = 1; k <= LAT + HI + 6; k++) begin
            step(1);
            ea = (k == LAT) || (k == LAT + HI);
            eb = (k >= LAT) && (k <= LAT + HI + 3);
            checks++; if (out_a[1] !== ea) $display("FAIL retrig_out k=%0d: got %b expected %b", k, out_a[1], ea); else passes++;
            checks++; if (out_b[1] !== eb) $display("FAIL retrig_out_p4 k=%0d: got %b expected %b", k, out_b[1], eb); else passes++;
            if (k == HI) in = 4'b0000;
        end
        checks++; if (cnt_b !== 8'd2) $display("FAIL retrig_cnt: got %0d expected 2", cnt_b); else passes++;
    endtask

    task automatic test_fall_only;
        logic [3:0] exp;
        do_reset(4'h0, 8'h20);
        step(ARM + 1);
        in = 4'b0100;
        for (int k = 1; k <= 4 + LAT + 4; k++) begin
            step(1);
            exp = (k == 4 + LAT) ? 4'b0100 : 4'b0000;
            checks++; if (out_a !== exp) $display("FAIL fall_only_out k=%0d: got %b expected %b", k, out_a, exp); else passes++;
            if (k == 4) in[2] = 1'b0;
            in[3] = ~in[3];
        end
        checks++; if (cnt_a !== 8'd1) $display("FAIL fall_only_cnt: got %0d expected 1", cnt_a); else passes++;
        checks++; if (sticky_a !== 4'b0100) $display("FAIL fall_only_sticky: got %b expected 0100", sticky_a); else passes++;
    endtask

    task automatic test_cnt_clr_sticky;
        do_reset(4'h0, 8'hFF);
        step(ARM + 1);
        for (int t = 0; t < 50; t++) begin
            in = ~in;
            step(GAP);
        end
        step(LAT + 1);
        checks++; if (cnt_a !== 8'd200) $display("FAIL bulk_cnt: got %0d expected 200", cnt_a); else passes++;
        checks++; if (cnt_c !== 3'd7) $display("FAIL bulk_cnt_sat: got %0d expected 7", cnt_c); else passes++;
        sticky_clr = 4'hF;
        step(1);
        sticky_clr = 4'h0;
        checks++; if (sticky_a !== 4'h0) $display("FAIL sticky_clear: got %b expected 0000", sticky_a); else passes++;
        mode = 8'h55;
        in   = 4'hF;
        for (int k = 1; k <= LAT; k++) begin
            step(1);
            if (k == LAT - 1) begin
                cnt_clr    = 1'b1;
                sticky_clr = 4'b0001;
            end
        end
        cnt_clr    = 1'b0;
        sticky_clr = 4'h0;
        checks++; if (cnt_a !== 8'd4) $display("FAIL clr_with_events: got %0d expected 4", cnt_a); else passes++;
        checks++; if (cnt_c !== 3'd4) $display("FAIL clr_with_events_c: got %0d expected 4", cnt_c); else passes++;
        checks++; if (sticky_a !== 4'hF) $display("FAIL sticky_set_wins: got %b expected 1111", sticky_a); else passes++;
        step(1);
        checks++; if (cnt_a !== 8'd4) $display("FAIL clr_hold: got %0d expected 4", cnt_a); else passes++;
    endtask

    task automatic test_saturate;
        do_reset(4'h0, 8'h03);
        step(ARM + 1);
        for (int t = 0; t < 9; t++) begin
            in[0] = ~in[0];
            step(GAP);
        end
        step(LAT + 1);
        checks++; if (cnt_c !== 3'd7) $display("FAIL saturate_c: got %0d expected 7", cnt_c); else passes++;
        checks++; if (cnt_a !== 8'd9) $display("FAIL saturate_a: got %0d expected 9", cnt_a); else passes++;
    endtask

    task automatic test_reset_mid_pulse;
        do_reset(4'h0, 8'h55);
        step(ARM + 1);
        in = 4'b0001;
        step(LAT + 1);
        checks++; if (out_b[0] !== 1'b1) $display("FAIL mid_pulse_high: got %b expected 1", out_b[0]); else passes++;
        reset = 1'b1;
        step(1);
        checks++; if ({out_b, sticky_b, cnt_b} !== 16'h0) $display("FAIL mid_pulse_reset: got %h expected 0000", {out_b, sticky_b, cnt_b}); else passes++;
        reset = 1'b0;
    endtask

`ifdef MULTI_EDGE_FILTER_EN
    task automatic test_filter;
        logic [3:0] seen;
        do_reset(4'h0, 8'h55);
        step(ARM + 1);
        in = 4'b0001;
        step(2);
        in = 4'b0000;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen = seen | out_a;
        end
        checks++; if (seen !== 4'h0) $display("FAIL glitch_out: got %b expected 0000", seen); else passes++;
        checks++; if (cnt_a !== 8'd0) $display("FAIL glitch_cnt: got %0d expected 0", cnt_a); else passes++;
        in = 4'b0001;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            checks++; if (out_a[0] !== (k == LAT)) $display("FAIL filter_out k=%0d: got %b expected %b", k, out_a[0], (k == LAT)); else passes++;
            if (k == 3) in = 4'b0000;
        end
        checks++; if (cnt_a !== 8'd1) $display("FAIL filter_cnt: got %0d expected 1", cnt_a); else passes++;
    endtask
`endif

    initial begin
        reset = 1'b1; in = '0; mode = '0; sticky_clr = '0; cnt_clr = 1'b0;
        test_reset();
        test_single_rise();
        test_retrigger();
        test_fall_only();
        test_cnt_clr_sticky();
        test_saturate();
        test_reset_mid_pulse();
`ifdef MULTI_EDGE_FILTER_EN
        test_filter();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
